// File: rtl/vend_ctrl_multi.sv
// Multi-channel vending controller: per-channel stock, coin credit accumulation,
// vend with change, cancel/timeout refund. Outputs are registered one-cycle pulses.
module vend_ctrl_multi #(
  parameter int N_PROD = 4,
  parameter int STOCK_W = 3,
  parameter int CREDIT_W = 6,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICE_LIST = {6'd30, 6'd40, 6'd40, 6'd30},
  parameter int TIMEOUT = 255,
  localparam int SEL_W = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        sel_valid,
  input  logic                        coin_10,
  input  logic                        coin_20,
  input  logic                        cancel,
  input  logic                        restock_valid,
  input  logic [SEL_W-1:0]            restock_id,
  input  logic [STOCK_W-1:0]          restock_qty,
  output logic [N_PROD-1:0]           vend,
  output logic [CREDIT_W-1:0]         change,
  output logic                        change_valid,
  output logic                        sold_out,
  output logic [CREDIT_W-1:0]         credit,
  output logic [N_PROD*STOCK_W-1:0]   stock,
  output logic [2:0]                  state
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_T = TIMER_W'(TIMEOUT);
  localparam logic [STOCK_W-1:0] STOCK_MAX = '1;
  localparam logic [CREDIT_W:0] TEN = (CREDIT_W+1)'(10);
  localparam logic [CREDIT_W:0] TWENTY = (CREDIT_W+1)'(20);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_PAY    = 3'd2,
    S_VEND   = 3'd3,
    S_REFUND = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [STOCK_W-1:0]   stock_q [N_PROD];
  logic [STOCK_W-1:0]   stock_d [N_PROD];
  logic [N_PROD-1:0]    vend_q, vend_d;
  logic [CREDIT_W-1:0]  change_q, change_d;
  logic                 change_valid_q, change_valid_d;
  logic                 sold_out_q, sold_out_d;

  logic [CREDIT_W:0]    pay_sum;
  logic [CREDIT_W:0]    price_ext;
  logic [CREDIT_W:0]    change_full;
  logic [STOCK_W:0]     rs_sum;
  logic [TIMER_W-1:0]   timer_inc;
  logic                 any_coin;

  function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] idx);
    return PRICE_LIST[int'(idx)*CREDIT_W +: CREDIT_W];
  endfunction

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    credit_d       = credit_q;
    timer_d        = timer_q;
    stock_d        = stock_q;
    vend_d         = '0;
    change_d       = '0;
    change_valid_d = 1'b0;
    sold_out_d     = 1'b0;
    rs_sum         = '0;
    any_coin       = coin_10 | coin_20;
    timer_inc      = timer_q + TIMER_W'(1);
    price_ext      = {1'b0, price_of(sel_q)};
    // Both coins in one cycle add 30; the extra bit keeps the sum from wrapping.
    pay_sum        = {1'b0, credit_q} + (coin_10 ? TEN : '0) + (coin_20 ? TWENTY : '0);
    change_full    = pay_sum - price_ext;

    case (state_q)
      S_IDLE: begin
        if (restock_valid && (int'(restock_id) < N_PROD)) begin
          rs_sum = {1'b0, stock_q[restock_id]} + {1'b0, restock_qty};
          stock_d[restock_id] = rs_sum[STOCK_W] ? STOCK_MAX : rs_sum[STOCK_W-1:0];
        end
        // sold_out is decided here from post-restock stock so the pulse lines up with CHECK.
        if (sel_valid && (int'(sel) < N_PROD)) begin
          sel_d      = sel;
          state_d    = S_CHECK;
          sold_out_d = (stock_d[sel] == '0);
        end
      end
      S_CHECK: begin
        if (stock_q[sel_q] == '0) begin
          state_d = S_IDLE;
        end else begin
          credit_d = '0;
          timer_d  = '0;
          state_d  = S_PAY;
        end
      end
      S_PAY: begin
        credit_d = pay_sum[CREDIT_W-1:0];
        timer_d  = any_coin ? '0 : timer_inc;
        if (pay_sum >= price_ext) begin
          state_d        = S_VEND;
          vend_d[sel_q]  = 1'b1;
          stock_d[sel_q] = stock_q[sel_q] - STOCK_W'(1);
          change_d       = change_full[CREDIT_W-1:0];
          change_valid_d = (change_full != '0);
          credit_d       = '0;
        end else if (cancel || (!any_coin && (timer_inc == TIMEOUT_T))) begin
          state_d        = S_REFUND;
          change_d       = pay_sum[CREDIT_W-1:0];
          change_valid_d = (pay_sum != '0);
          credit_d       = '0;
        end
      end
      S_VEND:   state_d = S_IDLE;
      S_REFUND: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      sel_q          <= '0;
      credit_q       <= '0;
      timer_q        <= '0;
      vend_q         <= '0;
      change_q       <= '0;
      change_valid_q <= 1'b0;
      sold_out_q     <= 1'b0;
      for (int i = 0; i < N_PROD; i++) stock_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      credit_q       <= credit_d;
      timer_q        <= timer_d;
      vend_q         <= vend_d;
      change_q       <= change_d;
      change_valid_q <= change_valid_d;
      sold_out_q     <= sold_out_d;
      for (int i = 0; i < N_PROD; i++) stock_q[i] <= stock_d[i];
    end
  end

  always_comb begin
    stock = '0;
    for (int i = 0; i < N_PROD; i++) stock[i*STOCK_W +: STOCK_W] = stock_q[i];
  end

  assign vend         = vend_q;
  assign change       = change_q;
  assign change_valid = change_valid_q;
  assign sold_out     = sold_out_q;
  assign credit       = credit_q;
  assign state        = state_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed bench for vend_ctrl_multi: table of per-cycle vectors plus hand sequences
// for timeout refund, stock saturation, restock during PAY and reset mid-transaction.
module tb_vend_ctrl_multi;

  logic        clk;
  logic        rst;
  logic [1:0]  sel;
  logic        sel_valid;
  logic        coin_10;
  logic        coin_20;
  logic        cancel;
  logic        restock_valid;
  logic [1:0]  restock_id;
  logic [2:0]  restock_qty;
  logic [3:0]  vend;
  logic [5:0]  change;
  logic        change_valid;
  logic        sold_out;
  logic [5:0]  credit;
  logic [11:0] stock;
  logic [2:0]  state;

  int n_checks = 0;
  int n_pass   = 0;

  vend_ctrl_multi dut (
    .clk(clk), .rst(rst), .sel(sel), .sel_valid(sel_valid),
    .coin_10(coin_10), .coin_20(coin_20), .cancel(cancel),
    .restock_valid(restock_valid), .restock_id(restock_id), .restock_qty(restock_qty),
    .vend(vend), .change(change), .change_valid(change_valid), .sold_out(sold_out),
    .credit(credit), .stock(stock), .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, sv;
    logic [1:0] sel;
    logic       c10, c20, can, rv;
    logic [1:0] rid;
    logic [2:0] rq;
    logic [2:0] e_state;
    logic [3:0] e_vend;
    logic [5:0] e_change;
    logic       e_cv, e_so;
    logic [5:0] e_credit;
    logic [11:0] e_stock;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [11:0] stk(input int s3, input int s2, input int s1, input int s0);
    return {3'(s3), 3'(s2), 3'(s1), 3'(s0)};
  endfunction

  task automatic add(input logic r, input logic sv, input int sl, input logic c10, input logic c20,
                     input logic can, input logic rv, input int rid, input int rq,
                     input int est, input int evd, input int ech, input logic ecv,
                     input logic eso, input int ecr, input logic [11:0] estk);
    vec_t v;
    v.rst = r; v.sv = sv; v.sel = 2'(sl); v.c10 = c10; v.c20 = c20; v.can = can;
    v.rv = rv; v.rid = 2'(rid); v.rq = 3'(rq);
    v.e_state = 3'(est); v.e_vend = 4'(evd); v.e_change = 6'(ech); v.e_cv = ecv;
    v.e_so = eso; v.e_credit = 6'(ecr); v.e_stock = estk;
    vecs.push_back(v);
  endtask

  // driver tasks
  task automatic clear_inputs();
    rst = 1'b0; sel_valid = 1'b0; sel = '0; coin_10 = 1'b0; coin_20 = 1'b0;
    cancel = 1'b0; restock_valid = 1'b0; restock_id = '0; restock_qty = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  // scoreboard comparison
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, " state"}, 32'(state), 32'(v.e_state));
    check({tag, " vend"}, 32'(vend), 32'(v.e_vend));
    check({tag, " change"}, 32'(change), 32'(v.e_change));
    check({tag, " change_valid"}, 32'(change_valid), 32'(v.e_cv));
    check({tag, " sold_out"}, 32'(sold_out), 32'(v.e_so));
    check({tag, " credit"}, 32'(credit), 32'(v.e_credit));
    check({tag, " stock"}, 32'(stock), 32'(v.e_stock));
  endtask

  initial begin
    vec_t hv;
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); #1;

    //   rst sv sel c10 c20 can rv id q | st vend chg cv so cr stock
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0,  0, stk(0,0,0,0));
    add(0, 0, 0, 0, 0, 0, 1, 0, 5,  0, 0,  0, 0, 0,  0, stk(0,0,0,5));
    add(0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0,  0, 0, 0,  0, stk(0,0,0,5));
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  2, 0,  0, 0, 0,  0, stk(0,0,0,5));
    add(0, 0, 0, 1, 0, 0, 0, 0, 0,  2, 0,  0, 0, 0, 10, stk(0,0,0,5));
    add(0, 0, 0, 0, 1, 0, 0, 0, 0,  3, 1,  0, 0, 0,  0, stk(0,0,0,4));
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0,  0, stk(0,0,0,4));
    add(0, 0, 0, 0, 0, 0, 1, 1, 1,  0, 0,  0, 0, 0,  0, stk(0,0,1,4));
    add(0, 1, 1, 0, 0, 0, 0, 0, 0,  1, 0,  0, 0, 0,  0, stk(0,0,1,4));
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  2, 0,  0, 0, 0,  0, stk(0,0,1,4));
    add(0, 0, 0, 0, 1, 0, 0, 0, 0,  2, 0,  0, 0, 0, 20, stk(0,0,1,4));
    add(0, 0, 0, 0, 1, 0, 0, 0, 0,  3, 2,  0, 0, 0,  0, stk(0,0,0,4));
    add(0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0,  0, 0, 0,  0, stk(0,0,0,4));
    add(0, 1, 1, 0, 0, 0, 0, 0, 0,  1, 0,  0, 0, 1,  0, stk(0,0,0,4));
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0,  0, stk(0,0,0,4));
    add(0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0,  0, 0, 0,  0, stk(0,0,0,4));
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  2, 0,  0, 0, 0,  0, stk(0,0,0,4));
    add(0, 0, 0, 0, 1, 0, 0, 0, 0,  2, 0,  0, 0, 0, 20, stk(0,0,0,4));
    add(0, 0, 0, 0, 1, 0, 0, 0, 0,  3, 1, 10, 1, 0,  0, stk(0,0,0,3));
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0,  0, stk(0,0,0,3));
    add(0, 1, 2, 0, 0, 0, 1, 2, 2,  1, 0,  0, 0, 0,  0, stk(0,2,0,3));
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  2, 0,  0, 0, 0,  0, stk(0,2,0,3));
    add(0, 0, 0, 1, 1, 0, 0, 0, 0,  2, 0,  0, 0, 0, 30, stk(0,2,0,3));
    add(0, 0, 0, 0, 0, 1, 0, 0, 0,  4, 0, 30, 1, 0,  0, stk(0,2,0,3));
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0,  0, stk(0,2,0,3));
    add(0, 1, 2, 0, 0, 0, 0, 0, 0,  1, 0,  0, 0, 0,  0, stk(0,2,0,3));
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  2, 0,  0, 0, 0,  0, stk(0,2,0,3));
    add(0, 0, 0, 1, 0, 1, 0, 0, 0,  4, 0, 10, 1, 0,  0, stk(0,2,0,3));
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0,  0, stk(0,2,0,3));
    add(0, 1, 2, 0, 0, 0, 0, 0, 0,  1, 0,  0, 0, 0,  0, stk(0,2,0,3));
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  2, 0,  0, 0, 0,  0, stk(0,2,0,3));
    add(0, 0, 0, 0, 0, 1, 0, 0, 0,  4, 0,  0, 0, 0,  0, stk(0,2,0,3));
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0,  0, stk(0,2,0,3));
    add(0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0,  0, 0, 0,  0, stk(0,2,0,3));

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; sel_valid = vecs[i].sv; sel = vecs[i].sel;
      coin_10 = vecs[i].c10; coin_20 = vecs[i].c20; cancel = vecs[i].can;
      restock_valid = vecs[i].rv; restock_id = vecs[i].rid; restock_qty = vecs[i].rq;
      step();
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Timeout refund on channel 3: coin then 255 idle cycles.
    restock_valid = 1'b1; restock_id = 2'd3; restock_qty = 3'd1;
    sel_valid = 1'b1; sel = 2'd3;
    step();
    check("to check_state", 32'(state), 32'd1);
    step();
    check("to pay_state", 32'(state), 32'd2);
    coin_10 = 1'b1;
    step();
    check("to credit", 32'(credit), 32'd10);
    for (int i = 0; i < 254; i++) step();
    check("to still_pay", 32'(state), 32'd2);
    check("to no_early_refund", 32'(change_valid), 32'd0);
    step();
    hv = '{rst:0, sv:0, sel:0, c10:0, c20:0, can:0, rv:0, rid:0, rq:0, e_state:3'd4,
           e_vend:4'd0, e_change:6'd10, e_cv:1'b1, e_so:1'b0, e_credit:6'd0,
           e_stock:stk(1,2,0,3)};
    check_all("to refund", hv);
    step();
    check("to idle", 32'(state), 32'd0);
    check("to cv_drop", 32'(change_valid), 32'd0);

    // Saturation of channel 0 at 7.
    restock_valid = 1'b1; restock_id = 2'd0; restock_qty = 3'd6;
    step();
    check("sat first", 32'(stock), 32'(stk(1,2,0,7)));
    restock_valid = 1'b1; restock_id = 2'd0; restock_qty = 3'd6;
    step();
    check("sat second", 32'(stock), 32'(stk(1,2,0,7)));

    // Restock ignored during PAY, then reset with credit pending.
    sel_valid = 1'b1; sel = 2'd0;
    step();
    step();
    check("pay entry", 32'(state), 32'd2);
    restock_valid = 1'b1; restock_id = 2'd1; restock_qty = 3'd3;
    step();
    check("pay restock_ignored", 32'(stock), 32'(stk(1,2,0,7)));
    coin_20 = 1'b1;
    step();
    check("pay credit20", 32'(credit), 32'd20);
    rst = 1'b1; coin_10 = 1'b1; cancel = 1'b1;
    step();
    hv = '{rst:0, sv:0, sel:0, c10:0, c20:0, can:0, rv:0, rid:0, rq:0, e_state:3'd0,
           e_vend:4'd0, e_change:6'd0, e_cv:1'b0, e_so:1'b0, e_credit:6'd0,
           e_stock:stk(0,0,0,0)};
    check_all("rst mid", hv);
    step();
    check("rst after cv", 32'(change_valid), 32'd0);
    check("rst after state", 32'(state), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
